// File: rtl/rx_if.sv
// Sample-stream bundle between the ADC/channel side and the rx matched filter.
// The master drives samples and the strobe; the slave (rx) returns the
// filtered sample, symbol strobe and sliced bit.
interface rx_if #(
  parameter int UPSAMPLE  = 4,
  parameter int IN_NBITS  = 8,
  parameter int OUT_NBITS = 8
);
  localparam int PHASE_NBITS = (UPSAMPLE > 1) ? $clog2(UPSAMPLE) : 1;

  logic                        enable;
  logic [PHASE_NBITS-1:0]      phase_sel;
  logic signed [IN_NBITS-1:0]  rx_in;
  logic signed [OUT_NBITS-1:0] rx_filt_out;
  logic                        rx_sym_valid;
  logic                        rx_bit;

  modport master (
    output enable, phase_sel, rx_in,
    input  rx_filt_out, rx_sym_valid, rx_bit
  );

  modport slave (
    input  enable, phase_sel, rx_in,
    output rx_filt_out, rx_sym_valid, rx_bit
  );
endinterface

// File: rtl/rx.sv
// Receive matched filter: NCOEF-tap FIR over the upsampled sample stream,
// saturation to OUT_NBITS, decimation by UPSAMPLE at a selectable phase and
// BPSK slicing. Every pipeline register advances only on enable.
module rx #(
  parameter int UPSAMPLE   = 4,
  parameter int NCOEF      = 24,
  parameter int COEF_NBITS = 8,
  parameter int COEF_FBITS = 7,
  parameter logic [COEF_NBITS*NCOEF-1:0] COEF = {(COEF_NBITS*NCOEF){1'b0}},
  parameter int IN_NBITS   = 8,
  parameter int IN_FBITS   = 7,
  parameter int OUT_NBITS  = 8,
  parameter int OUT_FBITS  = 7
) (
  input logic clk,
  input logic rst,
  rx_if.slave bus
);
  localparam int PHASE_NBITS = (UPSAMPLE > 1) ? $clog2(UPSAMPLE) : 1;
  localparam int PROD_NBITS  = IN_NBITS + COEF_NBITS;
  localparam int FULL_NBITS  = PROD_NBITS + $clog2(NCOEF);
  localparam int FULL_FBITS  = IN_FBITS + COEF_FBITS;
  // Output window inside the full-precision sum
  localparam int Q_HI        = FULL_FBITS + OUT_NBITS - OUT_FBITS - 1;
  localparam int Q_LO        = FULL_FBITS - OUT_FBITS;
  // Bits from the output sign up to the accumulator MSB must all agree
  localparam int GUARD_NBITS = FULL_NBITS - Q_HI;
  localparam int HALF        = NCOEF / 2;
  // Strobes stay suppressed until the first output built from a full buffer
  localparam int WARM_LAST   = NCOEF + 2;
  localparam int WARM_NBITS  = $clog2(WARM_LAST + 1);

  logic signed [COEF_NBITS-1:0] tap_r [NCOEF];
  logic signed [IN_NBITS-1:0]   buf_r [NCOEF];
  logic signed [PROD_NBITS-1:0] prod_s [NCOEF];
  logic signed [FULL_NBITS-1:0] sum_a_s, sum_b_s;
  logic signed [FULL_NBITS-1:0] sum_a_r, sum_b_r;
  logic signed [FULL_NBITS-1:0] full_r;
  logic [GUARD_NBITS-1:0]       guard_s;
  logic signed [OUT_NBITS-1:0]  filt_next_s;
  logic signed [OUT_NBITS-1:0]  filt_out_r;
  logic                         sym_valid_r;
  logic                         bit_r;
  logic [PHASE_NBITS-1:0]       out_cnt_r;
  logic [PHASE_NBITS-1:0]       out_cnt_next_s;
  logic [WARM_NBITS-1:0]        warm_cnt_r;
  logic                         warm_done_s;
  logic                         hit_s;

  // Tap register array, (re)loaded from the COEF parameter on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCOEF; k++) begin
        tap_r[k] <= COEF[COEF_NBITS*NCOEF-1-k*COEF_NBITS -: COEF_NBITS];
      end
    end
  end

  // S0: input delay line, newest sample at index 0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCOEF; k++) begin
        buf_r[k] <= {IN_NBITS{1'b0}};
      end
    end else if (bus.enable) begin
      buf_r[0] <= bus.rx_in;
      for (int k = 1; k < NCOEF; k++) begin
        buf_r[k] <= buf_r[k-1];
      end
    end
  end

  // Full-precision products and the two half-filter partial sums
  always_comb begin
    sum_a_s = {FULL_NBITS{1'b0}};
    sum_b_s = {FULL_NBITS{1'b0}};
    for (int k = 0; k < NCOEF; k++) begin
      prod_s[k] = PROD_NBITS'(buf_r[k]) * PROD_NBITS'(tap_r[k]);
      if (k < HALF) begin
        sum_a_s = sum_a_s + FULL_NBITS'(prod_s[k]);
      end else begin
        sum_b_s = sum_b_s + FULL_NBITS'(prod_s[k]);
      end
    end
  end

  // S1/S2: registered partial sums, then their registered total
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_a_r <= {FULL_NBITS{1'b0}};
      sum_b_r <= {FULL_NBITS{1'b0}};
      full_r  <= {FULL_NBITS{1'b0}};
    end else if (bus.enable) begin
      sum_a_r <= sum_a_s;
      sum_b_r <= sum_b_s;
      full_r  <= sum_a_r + sum_b_r;
    end
  end

  // Floor-truncate to the output format, clamping when the guard bits disagree
  always_comb begin
    guard_s = full_r[FULL_NBITS-1:Q_HI];
    if ((guard_s == {GUARD_NBITS{1'b0}}) || (guard_s == {GUARD_NBITS{1'b1}})) begin
      filt_next_s = full_r[Q_HI:Q_LO];
    end else if (full_r[FULL_NBITS-1]) begin
      filt_next_s = {1'b1, {(OUT_NBITS-1){1'b0}}};
    end else begin
      filt_next_s = {1'b0, {(OUT_NBITS-1){1'b1}}};
    end
  end

  // Decimation phase counter next value and symbol-strobe qualifier
  always_comb begin
    if (out_cnt_r == PHASE_NBITS'(UPSAMPLE - 1)) begin
      out_cnt_next_s = {PHASE_NBITS{1'b0}};
    end else begin
      out_cnt_next_s = out_cnt_r + {{(PHASE_NBITS-1){1'b0}}, 1'b1};
    end
    warm_done_s = (warm_cnt_r == WARM_NBITS'(WARM_LAST));
    hit_s       = (out_cnt_r == bus.phase_sel) && warm_done_s;
  end

  // Phase counter and saturating warm-up enable counter
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt_r  <= {PHASE_NBITS{1'b0}};
      warm_cnt_r <= {WARM_NBITS{1'b0}};
    end else if (bus.enable) begin
      out_cnt_r <= out_cnt_next_s;
      if (!warm_done_s) begin
        warm_cnt_r <= warm_cnt_r + {{(WARM_NBITS-1){1'b0}}, 1'b1};
      end
    end
  end

  // S3: filter output register
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_out_r <= {OUT_NBITS{1'b0}};
    end else if (bus.enable) begin
      filt_out_r <= filt_next_s;
    end
  end

  // S3: one-cycle symbol strobe and slicer (non-negative sample -> 1)
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_valid_r <= 1'b0;
      bit_r       <= 1'b0;
    end else if (bus.enable && hit_s) begin
      sym_valid_r <= 1'b1;
      bit_r       <= ~filt_next_s[OUT_NBITS-1];
    end else begin
      sym_valid_r <= 1'b0;
    end
  end

  assign bus.rx_filt_out  = filt_out_r;
  assign bus.rx_sym_valid = sym_valid_r;
  assign bus.rx_bit       = bit_r;
endmodule

// File: tb/tb_rx.sv
// Directed self-checking bench for rx with all taps set to 0x40 (0.5).
module tb_rx;
  localparam int NCOEF = 24;
  localparam logic [8*NCOEF-1:0] TAPS = {NCOEF{8'h40}};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  rx_if #(.UPSAMPLE(4), .IN_NBITS(8), .OUT_NBITS(8)) bus ();

  rx #(
    .UPSAMPLE(4), .NCOEF(NCOEF), .COEF_NBITS(8), .COEF_FBITS(7), .COEF(TAPS),
    .IN_NBITS(8), .IN_FBITS(7), .OUT_NBITS(8), .OUT_FBITS(7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, let the edge pass, sample 1 time unit after it
  task automatic step(input logic en, input logic [7:0] x);
    bus.enable = en;
    bus.rx_in  = x;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step(1'b0, 8'h00);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.rx_filt_out !== 8'h00) begin
      errors++; $display("FAIL reset_filt got=%h want=00", bus.rx_filt_out);
    end
    checks++;
    if (bus.rx_sym_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%b want=0", bus.rx_sym_valid);
    end
    checks++;
    if (bus.rx_bit !== 1'b0) begin
      errors++; $display("FAIL reset_bit got=%b want=0", bus.rx_bit);
    end
  endtask

  // Single impulse: 24 outputs of amp*0.5 starting 3 enables later
  task automatic test_impulse(input logic [7:0] amp, input logic [7:0] want_pk);
    logic [7:0] want;
    apply_reset();
    bus.phase_sel = 2'd0;
    for (int k = 1; k <= 32; k++) begin
      step(1'b1, (k == 1) ? amp : 8'h00);
      want = (k >= 4 && k <= 27) ? want_pk : 8'h00;
      checks++;
      if (bus.rx_filt_out !== want) begin
        errors++; $display("FAIL impulse_%h k=%0d got=%h want=%h", amp, k, bus.rx_filt_out, want);
      end
    end
  endtask

  // Constant 0x40: ramps 0x20,0x40,0x60 then clamps to 0x7F
  task automatic test_pos_saturation();
    logic [7:0] want;
    apply_reset();
    for (int k = 1; k <= 30; k++) begin
      step(1'b1, 8'h40);
      case (k)
        4:       want = 8'h20;
        5:       want = 8'h40;
        6:       want = 8'h60;
        default: want = (k < 4) ? 8'h00 : 8'h7F;
      endcase
      checks++;
      if (bus.rx_filt_out !== want) begin
        errors++; $display("FAIL pos_sat k=%0d got=%h want=%h", k, bus.rx_filt_out, want);
      end
    end
  endtask

  // Constant -1.0: 0xC0, exact -1.0 (0x80), then clamped 0x80
  task automatic test_neg_boundary();
    logic [7:0] want;
    apply_reset();
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 8'h80);
      want = (k < 4) ? 8'h00 : ((k == 4) ? 8'hC0 : 8'h80);
      checks++;
      if (bus.rx_filt_out !== want) begin
        errors++; $display("FAIL neg_bound k=%0d got=%h want=%h", k, bus.rx_filt_out, want);
      end
    end
  endtask

  // Phase sweep: +0x08 for 39 enables then -0x08; strobe timing and slicing
  task automatic test_decimation();
    logic want_v;
    for (int ph = 0; ph < 4; ph++) begin
      apply_reset();
      bus.phase_sel = 2'(ph);
      for (int k = 1; k <= 80; k++) begin
        step(1'b1, (k < 40) ? 8'h08 : 8'hF8);
        want_v = (k >= 27) && (((k - 1) % 4) == ph);
        checks++;
        if (bus.rx_sym_valid !== want_v) begin
          errors++; $display("FAIL dec_valid ph=%0d k=%0d got=%b want=%b", ph, k, bus.rx_sym_valid, want_v);
        end
        if (want_v && k <= 42) begin
          checks++;
          if (bus.rx_bit !== 1'b1) begin
            errors++; $display("FAIL dec_bit_pos ph=%0d k=%0d got=%b want=1", ph, k, bus.rx_bit);
          end
        end
        if (want_v && k >= 70) begin
          checks++;
          if (bus.rx_bit !== 1'b0) begin
            errors++; $display("FAIL dec_bit_neg ph=%0d k=%0d got=%b want=0", ph, k, bus.rx_bit);
          end
        end
        if (k == 30 || k == 80) begin
          checks++;
          if (bus.rx_filt_out !== ((k == 30) ? 8'h60 : 8'hA0)) begin
            errors++; $display("FAIL dec_filt ph=%0d k=%0d got=%h", ph, k, bus.rx_filt_out);
          end
        end
      end
    end
  endtask

  // Constant 0x40 with enable gaps (2 of every 3 clocks), phase 2
  task automatic test_enable_gaps();
    int         k;
    int         c;
    logic       en;
    logic       want_v;
    logic [7:0] want;
    apply_reset();
    bus.phase_sel = 2'd2;
    k    = 0;
    c    = 0;
    want = 8'h00;
    while (k < 40 && c < 200) begin
      en = ((c % 3) != 1);
      c++;
      step(en, 8'h40);
      if (en) begin
        k++;
        case (k)
          4:       want = 8'h20;
          5:       want = 8'h40;
          6:       want = 8'h60;
          default: want = (k < 4) ? 8'h00 : 8'h7F;
        endcase
        want_v = (k >= 27) && (((k - 1) % 4) == 2);
      end else begin
        want_v = 1'b0;
      end
      checks++;
      if (bus.rx_filt_out !== want) begin
        errors++; $display("FAIL gap_filt c=%0d k=%0d got=%h want=%h", c, k, bus.rx_filt_out, want);
      end
      checks++;
      if (bus.rx_sym_valid !== want_v) begin
        errors++; $display("FAIL gap_valid c=%0d k=%0d got=%b want=%b", c, k, bus.rx_sym_valid, want_v);
      end
    end
    checks++;
    if (k != 40) begin
      errors++; $display("FAIL gap_budget got=%0d want=40", k);
    end
  endtask

  // Reset pulse during the saturated run left by test_enable_gaps
  task automatic test_reset_mid();
    checks++;
    if (bus.rx_bit !== 1'b1) begin
      errors++; $display("FAIL mid_pre_bit got=%b want=1", bus.rx_bit);
    end
    rst = 1'b1;
    step(1'b1, 8'h40);
    rst = 1'b0;
    checks++;
    if ({bus.rx_filt_out, bus.rx_sym_valid, bus.rx_bit} !== 10'h000) begin
      errors++; $display("FAIL mid_clear got=%h/%b/%b want=00/0/0", bus.rx_filt_out, bus.rx_sym_valid, bus.rx_bit);
    end
    for (int k = 1; k <= 26; k++) begin
      step(1'b1, 8'h40);
      checks++;
      if (bus.rx_sym_valid !== 1'b0) begin
        errors++; $display("FAIL mid_warm k=%0d got=%b want=0", k, bus.rx_sym_valid);
      end
    end
    step(1'b1, 8'h40);
    checks++;
    if (bus.rx_sym_valid !== 1'b1 || bus.rx_filt_out !== 8'h7F || bus.rx_bit !== 1'b1) begin
      errors++; $display("FAIL mid_first got=%b/%h/%b want=1/7f/1", bus.rx_sym_valid, bus.rx_filt_out, bus.rx_bit);
    end
  endtask

  initial begin
    bus.enable    = 1'b0;
    bus.rx_in     = 8'h00;
    bus.phase_sel = 2'd0;
    test_reset();
    test_impulse(8'h40, 8'h20);
    test_impulse(8'hC0, 8'hE0);
    test_pos_saturation();
    test_neg_boundary();
    test_decimation();
    test_enable_gaps();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
